// File: rtl/sel_arbiter_pkg.sv
// Shared types and constants for the two-requester select arbiter.
package sel_arbiter_pkg;

    // Arbiter phase: idle, holding a grant for A or B, or blanking between grants
    typedef enum logic [1:0] {
        StIdle,
        StHoldA,
        StHoldB,
        StGuard
    } sel_state_t;

    // Mux select encoding seen by the downstream datapath
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Width of the shared hold/guard counter
    localparam int unsigned SEL_CNT_W = 8;

endpackage : sel_arbiter_pkg

// File: rtl/sel_arbiter.sv
// Two-requester select arbiter driving a datapath mux select (1 = A, 0 = B).
// Enforces a minimum hold per grant and a blanking guard interval on every
// switch so the mux settles before the new grant is issued.
// Optional checks: define SEL_ARBITER_ASSERT_EN to compile in invariant assertions.
module sel_arbiter
    import sel_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MIN = 4,
    parameter int unsigned GUARD    = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_sel,
    output logic o_gnt_a,
    output logic o_gnt_b,
    output logic o_busy
);

    localparam logic [SEL_CNT_W-1:0] HOLD_CNT   = SEL_CNT_W'(HOLD_MIN);
    localparam logic [SEL_CNT_W-1:0] GUARD_LAST = SEL_CNT_W'(GUARD - 1);

    sel_state_t           state_q, state_d;
    logic [SEL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tgt_q, tgt_d;
    logic                 sel_q, sel_d;
    logic                 gnt_a_q, gnt_a_d;
    logic                 gnt_b_q, gnt_b_d;
    logic                 busy_q, busy_d;

    logic                 own_is_a;
    logic                 req_own;
    logic                 req_oth;
    logic                 req_tgt;
    logic                 do_switch;
    logic [SEL_CNT_W-1:0] cnt_inc;

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        sel_d     = sel_q;
        gnt_a_d   = gnt_a_q;
        gnt_b_d   = gnt_b_q;
        busy_d    = busy_q;
        own_is_a  = (state_q == StHoldA);
        req_own   = own_is_a ? i_req_a : i_req_b;
        req_oth   = own_is_a ? i_req_b : i_req_a;
        req_tgt   = (tgt_q == SEL_A) ? i_req_a : i_req_b;
        do_switch = 1'b0;
        // Count includes the current cycle, so preemption lands HOLD_MIN edges after the grant
        cnt_inc   = (cnt_q >= HOLD_CNT) ? HOLD_CNT : cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (i_req_a) begin
                    state_d = StHoldA;
                    sel_d   = SEL_A;
                    gnt_a_d = 1'b1;
                    cnt_d   = '0;
                end else if (i_req_b) begin
                    state_d = StHoldB;
                    sel_d   = SEL_B;
                    gnt_b_d = 1'b1;
                    cnt_d   = '0;
                end
            end

            StHoldA, StHoldB: begin
                cnt_d = cnt_inc;
                if (!req_own && req_oth) begin
                    do_switch = 1'b1;
                end else if (!req_own) begin
                    state_d = StIdle;
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    cnt_d   = '0;
                end else if (req_oth && (cnt_inc >= HOLD_CNT)) begin
                    do_switch = 1'b1;
                end

                // Select moves to the new owner at the start of blanking, not at grant time
                if (do_switch) begin
                    state_d = StGuard;
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    busy_d  = 1'b1;
                    sel_d   = own_is_a ? SEL_B : SEL_A;
                    tgt_d   = own_is_a ? SEL_B : SEL_A;
                    cnt_d   = '0;
                end
            end

            StGuard: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GUARD_LAST) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    if (req_tgt) begin
                        state_d = (tgt_q == SEL_A) ? StHoldA : StHoldB;
                        gnt_a_d = (tgt_q == SEL_A);
                        gnt_b_d = (tgt_q == SEL_B);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef SEL_ARBITER_ASSERT_EN
        sel_known: assert final (^sel_q !== 1'bx)
            else $error("sel_arbiter: o_sel is X");
        gnt_onehot: assert final (!(gnt_a_q && gnt_b_q))
            else $error("sel_arbiter: both grants high");
        gnt_busy: assert final (!(busy_q && (gnt_a_q || gnt_b_q)))
            else $error("sel_arbiter: grant high during guard");
        gnt_sel: assert final ((!gnt_a_q || sel_q == SEL_A) && (!gnt_b_q || sel_q == SEL_B))
            else $error("sel_arbiter: select disagrees with grant");
`endif
    end

    // State, counter and registered outputs; reset applies immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= SEL_B;
            sel_q   <= SEL_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
        end
    end

    assign o_sel   = sel_q;
    assign o_gnt_a = gnt_a_q;
    assign o_gnt_b = gnt_b_q;
    assign o_busy  = busy_q;

endmodule : sel_arbiter

// File: tb/tb_sel_arbiter.sv
// Self-checking bench for sel_arbiter: directed scenarios followed by random
// request traffic, all compared against a cycle-level behavioural model.
module tb_sel_arbiter;

    localparam int unsigned HOLD_MIN = 4;
    localparam int unsigned GUARD    = 2;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: owner 0 = none, 1 = A, 2 = B
    int   m_owner;
    int   m_held;
    int   m_guard_left;
    int   m_dest;
    logic m_sel;

    always #5 clk = ~clk;

    sel_arbiter #(
        .HOLD_MIN (HOLD_MIN),
        .GUARD    (GUARD)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req_a (req_a),
        .i_req_b (req_b),
        .o_sel   (sel),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b),
        .o_busy  (busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_sel"},   sel,   m_sel);
        chk({tag, "_gnt_a"}, gnt_a, m_owner == 1 && m_guard_left == 0);
        chk({tag, "_gnt_b"}, gnt_b, m_owner == 2 && m_guard_left == 0);
        chk({tag, "_busy"},  busy,  m_guard_left > 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   sel,   1'b0);
        chk({tag, "_gnt_a"}, gnt_a, 1'b0);
        chk({tag, "_gnt_b"}, gnt_b, 1'b0);
        chk({tag, "_busy"},  busy,  1'b0);
    endtask

    task automatic model_reset();
        m_owner      = 0;
        m_held       = 0;
        m_guard_left = 0;
        m_dest       = 0;
        m_sel        = 1'b0;
    endtask

    // One rising edge of the arbiter's rules with the given sampled requests
    task automatic model_edge(input logic a, input logic b);
        logic own;
        logic oth;
        if (m_guard_left > 0) begin
            m_guard_left--;
            if (m_guard_left == 0) begin
                if ((m_dest == 1 && a) || (m_dest == 2 && b)) begin
                    m_owner = m_dest;
                    m_held  = 0;
                end else begin
                    m_owner = 0;
                end
            end
        end else if (m_owner == 0) begin
            if (a) begin
                m_owner = 1;
                m_sel   = 1'b1;
                m_held  = 0;
            end else if (b) begin
                m_owner = 2;
                m_sel   = 1'b0;
                m_held  = 0;
            end
        end else begin
            own = (m_owner == 1) ? a : b;
            oth = (m_owner == 1) ? b : a;
            m_held++;
            if (oth && (!own || m_held >= int'(HOLD_MIN))) begin
                m_dest       = 3 - m_owner;
                m_owner      = 0;
                m_guard_left = int'(GUARD);
                m_sel        = (m_dest == 1);
            end else if (!own) begin
                m_owner = 0;
            end
        end
    endtask

    // Called at a falling edge: drive, clock, update model, check, return at next falling edge
    task automatic tick(input logic a, input logic b, input string tag);
        req_a = a;
        req_b = b;
        @(posedge clk);
        model_edge(a, b);
        #1;
        chk_model(tag);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 1'bx;
        req_b = 1'bx;
        model_reset();

        // Reset with unknown requests: outputs at reset values, select never X
        @(negedge clk);
        chk_reset_vals("rst_x");
        chk("rst_sel_known", (^sel) !== 1'bx, 1'b1);
        @(negedge clk);
        chk("rst_sel_known2", (^sel) !== 1'bx, 1'b1);
        req_a = 1'b0;
        req_b = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // Simultaneous requests from idle: A wins
        tick(1'b1, 1'b1, "both");
        tick(1'b0, 1'b0, "both_rel");

        // A granted, B requests one cycle later: A held for HOLD_MIN, then guard, then B
        tick(1'b1, 1'b0, "pre_ga");
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, "preempt");
        chk("preempt_end_gnt_b", gnt_b, 1'b1);
        tick(1'b0, 1'b0, "pre_rel");

        // B drops during guard with A low: guard runs full length, idle, select stays B
        tick(1'b1, 1'b0, "drop_ga");
        tick(1'b0, 1'b1, "drop_sw");
        tick(1'b0, 1'b0, "drop_g1");
        tick(1'b0, 1'b0, "drop_g2");
        chk("drop_sel_b", sel, 1'b0);
        tick(1'b0, 1'b0, "drop_idle");

        // Release after one cycle with B idle, then re-request: no guard
        tick(1'b1, 1'b0, "rel_ga");
        tick(1'b0, 1'b0, "rel_idle");
        tick(1'b1, 1'b0, "rel_again");

        // Reset asserted between edges in the middle of a guard
        tick(1'b0, 1'b1, "mid_sw");
        chk("mid_busy_pre", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        model_reset();
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Random traffic with varying request density
        for (int i = 0; i < 600; i++) begin
            int unsigned dens;
            logic ra;
            logic rb;
            dens = (i / 150) + 1;
            ra   = ($urandom_range(0, 4) < dens);
            rb   = ($urandom_range(0, 4) < dens);
            tick(ra, rb, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sel_arbiter

// File: doc/sel_arbiter.md
# sel_arbiter

Two-requester select arbiter that drives the mux select line (`z` of interface `I`) consumed by the downstream datapath mux, where 1 selects path A and 0 selects path B. Guarantees the select is never X from reset onward, enforces a minimum hold time per grant, and inserts a blanking guard interval on every switch so the consumer's mux settles before a new grant is issued. Sits in the parent next to the mux; its `o_sel` is assigned onto `I.z`.

## Interface
- `HOLD_MIN`, default 4: minimum cycles a grant is held before the other requester may preempt; legal range 1..255.
- `GUARD`, default 2: blanking cycles between dropping one grant and issuing the other; legal range 1..255.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_req_a`  in  1  request for path A; level-sensitive.
- `i_req_b`  in  1  request for path B; level-sensitive.
- `o_sel`  out  1  mux select, registered (1 = A, 0 = B).
- `o_gnt_a`  out  1  grant to A, registered.
- `o_gnt_b`  out  1  grant to B, registered.
- `o_busy`  out  1  high during the guard interval, registered.

## Operation
- States: IDLE, HOLD_A, HOLD_B, GUARD. An 8-bit counter `cnt` is shared by the hold and guard phases. A 1-bit `tgt` records the destination of a switch.
- Reset values: state IDLE, `o_sel`=0, `o_gnt_a`=0, `o_gnt_b`=0, `o_busy`=0, `cnt`=0. Asserting reset mid-operation forces all of these values immediately, without waiting for a clock edge.
- IDLE:
  - `i_req_a` high: go to HOLD_A with `o_sel`=1 and `o_gnt_a`=1. A wins if both requests are high.
  - Otherwise `i_req_b` high: go to HOLD_B with `o_sel`=0 and `o_gnt_b`=1.
  - No guard interval is inserted from IDLE.
  - `o_sel` keeps its last value while in IDLE.
- HOLD_x (x = current owner, y = other requester): `cnt` increments and saturates at `HOLD_MIN`. The first matching rule applies:
  - `req_x` low and `req_y` high: switch.
  - `req_x` low and `req_y` low: go to IDLE and drop the grant.
  - `req_y` high and `cnt` >= `HOLD_MIN`: switch (preemption).
  - Otherwise: stay.
- Switch sequence:
  - Enter GUARD, drop both grants, set `o_busy`=1, and set `o_sel` to y in the same edge.
  - Set `tgt`=y and `cnt`=0.
- GUARD: `cnt` increments. When `cnt` = `GUARD`-1:
  - `req_tgt` still high: go to HOLD_tgt with its grant set and `cnt` reset to 0.
  - `req_tgt` low: go to IDLE.
  - In both cases `o_busy`=0.
  - Request changes during GUARD do not shorten it or redirect it.
- Invariants:
  - `o_gnt_a` and `o_gnt_b` are never both 1.
  - No grant is high while `o_busy`=1.
  - While `o_gnt_a`=1, `o_sel`=1; while `o_gnt_b`=1, `o_sel`=0.

## Timing
- Grant latency from IDLE: a request sampled high at edge N gives a grant high after edge N.
- Release: the owner's request sampled low at edge N drops its grant after edge N.
- Switch latency: the switch condition sampled at edge N causes:
  - `o_sel` to change and `o_busy` to rise after edge N;
  - the new grant to rise after edge N+`GUARD`;
  - exactly `GUARD` cycles with `o_busy`=1.
- Preemption: a grant issued after edge M can be preempted at the earliest at edge M+`HOLD_MIN`.
- All outputs come directly from flops; there are no combinational paths from input to output.

## Configuration
- `SEL_ARBITER_ASSERT_EN`: when defined, the block compiles in the following `assert final` checks, each of which calls `$error` when it fails:
  - `^o_sel !== 'x`, checked in the always_comb next-state block;
  - the grants are not both high (one-hot-or-zero);
  - no grant is high while `o_busy` is high;
  - the `o_sel`/grant consistency invariant above.
- Without the macro the block contains no assertions. Functional behaviour is identical either way.

## Structure
- Package `sel_arbiter_pkg` holds:
  - the state enum typedef `sel_state_t` (IDLE, HOLD_A, HOLD_B, GUARD);
  - the path encoding constants `SEL_A`=1'b1 and `SEL_B`=1'b0;
  - the counter width constant `SEL_CNT_W`=8.
- Single module: one always_ff for state and outputs, one always_comb for next state. The counter is inline; no sub-module.

## Test plan
All scenarios use `HOLD_MIN`=4 and `GUARD`=2 unless stated.
- Reset: hold `i_rst`=1 with the requests at X, then release -> all outputs 0 and `o_sel` never X, including while the requests are X.
- Both requests rise in the same cycle from IDLE -> `o_gnt_a`=1 and `o_sel`=1 one edge later; `o_gnt_b` stays 0.
- A granted and B raises its request 1 cycle after the A grant -> the A grant holds until 4 cycles have elapsed; then `o_busy`=1 for exactly 2 cycles with `o_sel`=0 on its first cycle; then `o_gnt_b`=1.
- B drops its request during GUARD and A also low -> the guard still lasts 2 cycles, then IDLE with both grants 0 and `o_sel` left at 0.
- A releases after 1 cycle and B is idle -> IDLE with no guard. A re-requests -> `o_gnt_a` one edge later with no `o_busy` pulse.
- Reset asserted mid-GUARD between clock edges -> outputs go to their reset values immediately. With `SEL_ARBITER_ASSERT_EN` defined, no assertion fires anywhere in the run.
